// File: rtl/irq_pend_pkg.sv
// Shared types and constants for the interrupt pending controller.
// FSM state encoding plus request width / index width.
package irq_pend_pkg;

  localparam int IRQ_N     = 4;
  localparam int IRQ_IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_edge_sync.sv
// One request line: optional 2-flop synchroniser (IRQ_PEND_SYNC_EN) and
// rising-edge detect. Ports: clk, rst_n, d (raw line), rise (edge pulse).
module irq_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic samp;
  logic prev;

`ifdef IRQ_PEND_SYNC_EN
  logic s1;
  logic s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign samp = s2;
`else
  assign samp = d;
`endif

  // prev clears on reset, so a line held high through reset is a new edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= samp;
  end

  assign rise = samp & ~prev;

endmodule

// File: rtl/irq_pend_ctrl.sv
// Request capture + present/ack/eoi handshake for a 4-input priority encoder.
// Ports: clk, rst_n, req_in, mask, ack, ack_idx, eoi -> pend_o, irq_o,
// svc_o, svc_idx, err_o. Macro IRQ_PEND_SYNC_EN adds input synchronisers.
module irq_pend_ctrl
  import irq_pend_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IRQ_N-1:0]     req_in,
  input  logic [IRQ_N-1:0]     mask,
  input  logic                 ack,
  input  logic [IRQ_IDX_W-1:0] ack_idx,
  input  logic                 eoi,
  output logic [IRQ_N-1:0]     pend_o,
  output logic                 irq_o,
  output logic                 svc_o,
  output logic [IRQ_IDX_W-1:0] svc_idx,
  output logic                 err_o
);

  irq_state_e state;
  irq_state_e state_d;

  logic [IRQ_N-1:0]     rise;
  logic [IRQ_N-1:0]     pending;
  logic [IRQ_N-1:0]     pend_d;
  logic [IRQ_N-1:0]     masked;
  logic [IRQ_N-1:0]     clr;
  logic [IRQ_N-1:0]     pout_d;
  logic [IRQ_IDX_W-1:0] svc_d;
  logic                 legal;
  logic                 err_d;

  for (genvar i = 0; i < IRQ_N; i++) begin : g_edge
    irq_edge_sync u_edge (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (req_in[i]),
      .rise (rise[i])
    );
  end

  assign masked = pending & mask;
  assign legal  = (state == PRESENT) && masked[ack_idx];

  always_comb begin
    state_d = state;
    clr     = '0;
    svc_d   = svc_idx;
    err_d   = ack && !legal;
    unique case (state)
      IDLE: begin
        if (|masked) state_d = PRESENT;
      end
      PRESENT: begin
        if (ack && legal) begin
          clr[ack_idx] = 1'b1;
          svc_d        = ack_idx;
          state_d      = SERVICE;
        end else if (masked == '0) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // set wins over clear so a fresh edge is never lost
    pend_d = (pending & ~clr) | rise;
    // pend_o is registered to keep mask off any comb output path
    pout_d = (state_d == PRESENT) ? (pend_d & mask) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
      svc_idx <= '0;
      err_o   <= 1'b0;
      pend_o  <= '0;
    end else begin
      state   <= state_d;
      pending <= pend_d;
      svc_idx <= svc_d;
      err_o   <= err_d;
      pend_o  <= pout_d;
    end
  end

  assign irq_o = (state == PRESENT);
  assign svc_o = (state == SERVICE);

endmodule
